// File: rtl/snoop_responder_pkg.sv
// Shared types and width helpers for the last-level cache snoop responder.
// The MESI, bus-op, snoop-result and L2->L1 message encodings match the bus and L1 interfaces.
package snoop_responder_pkg;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_t;

   typedef enum logic [1:0] {
      OP_READ       = 2'd0,
      OP_WRITE      = 2'd1,
      OP_INVALIDATE = 2'd2,
      OP_RWIM       = 2'd3
   } bus_op_t;

   typedef enum logic [1:0] {
      SNOOP_NOHIT = 2'd0,
      SNOOP_HIT   = 2'd1,
      SNOOP_HITM  = 2'd2,
      SNOOP_RSVD  = 2'd3
   } snoop_result_t;

   typedef enum logic [1:0] {
      MSG_NONE           = 2'd0,
      MSG_GETLINE        = 2'd1,
      MSG_INVALIDATELINE = 2'd2,
      MSG_EVICTLINE      = 2'd3
   } l2l1_msg_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_RESULT,
      ST_L1MSG,
      ST_WB,
      ST_UPDATE
   } resp_state_t;

   localparam int DEF_I_SIZE = 32;
   localparam int DEF_C_SIZE = 24;
   localparam int DEF_D_SIZE = 6;
   localparam int DEF_A_SIZE = 8;

   // Set-index width: capacity bits minus line-offset bits minus way-select bits.
   function automatic int idx_width(input int c_size, input int d_size, input int a_size);
      return c_size - d_size - $clog2(a_size);
   endfunction

   // Tag width: whatever address bits remain above the index and line offset.
   function automatic int tag_width(input int i_size, input int c_size, input int d_size,
                                    input int a_size);
      return i_size - idx_width(c_size, d_size, a_size) - d_size;
   endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Bus-side bundle of the snoop responder: snoop handshake, tag lookup, state write,
// L1 message channel and writeback channel. 'slave' is the responder's view, 'master'
// is the view of the surrounding cache / bus environment.
interface snoop_responder_if
   import snoop_responder_pkg::*;
#(
   parameter int I_SIZE = DEF_I_SIZE,
   parameter int C_SIZE = DEF_C_SIZE,
   parameter int D_SIZE = DEF_D_SIZE,
   parameter int A_SIZE = DEF_A_SIZE
);
   localparam int IDX_W = idx_width(C_SIZE, D_SIZE, A_SIZE);
   localparam int TAG_W = tag_width(I_SIZE, C_SIZE, D_SIZE, A_SIZE);
   localparam int WAY_W = $clog2(A_SIZE);

   logic              snoop_valid;
   logic              snoop_ready;
   logic [1:0]        snoop_op;
   logic [I_SIZE-1:0] snoop_addr;
   logic              lk_req;
   logic [IDX_W-1:0]  lk_index;
   logic [TAG_W-1:0]  lk_tag;
   logic              lk_hit;
   logic [WAY_W-1:0]  lk_way;
   logic [1:0]        lk_state;
   logic              st_we;
   logic [IDX_W-1:0]  st_index;
   logic [WAY_W-1:0]  st_way;
   logic [1:0]        st_state;
   logic [1:0]        snoop_result;
   logic              result_valid;
   logic              l1_valid;
   logic [1:0]        l1_msg;
   logic              l1_ack;
   logic              wb_valid;
   logic [I_SIZE-1:0] wb_addr;
   logic              wb_ready;

   modport slave (
      input  snoop_valid, snoop_op, snoop_addr, lk_hit, lk_way, lk_state, l1_ack, wb_ready,
      output snoop_ready, lk_req, lk_index, lk_tag, st_we, st_index, st_way, st_state,
             snoop_result, result_valid, l1_valid, l1_msg, wb_valid, wb_addr
   );

   modport master (
      output snoop_valid, snoop_op, snoop_addr, lk_hit, lk_way, lk_state, l1_ack, wb_ready,
      input  snoop_ready, lk_req, lk_index, lk_tag, st_we, st_index, st_way, st_state,
             snoop_result, result_valid, l1_valid, l1_msg, wb_valid, wb_addr
   );

endinterface

// File: rtl/snoop_responder_action_decode.sv
// Combinational MESI action table for a snooped bus op: from the op and the looked-up
// line state, decide the snoop result, the L1 message, whether dirty data must be
// written back, the new line state and whether that state actually needs writing.
module snoop_action_decode
   import snoop_responder_pkg::*;
(
   input  bus_op_t       op,
   input  logic          hit,
   input  mesi_t         state,
   output snoop_result_t result,
   output l2l1_msg_t     msg,
   output logic          wb,
   output mesi_t         next_state,
   output logic          update
);

   mesi_t eff_state;

   // A miss behaves exactly like an Invalid line; default is "no action, state unchanged".
   always_comb begin
      eff_state  = hit ? state : MESI_I;
      result     = SNOOP_NOHIT;
      msg        = MSG_NONE;
      wb         = 1'b0;
      next_state = eff_state;
      unique case (op)
         OP_READ: begin
            if (eff_state == MESI_M) begin
               result     = SNOOP_HITM;
               msg        = MSG_GETLINE;
               wb         = 1'b1;
               next_state = MESI_S;
            end else if (eff_state == MESI_E || eff_state == MESI_S) begin
               result     = SNOOP_HIT;
               next_state = MESI_S;
            end
         end
         OP_WRITE: begin
         end
         OP_INVALIDATE: begin
            if (eff_state == MESI_S) begin
               result     = SNOOP_HIT;
               msg        = MSG_INVALIDATELINE;
               next_state = MESI_I;
            end
         end
         OP_RWIM: begin
            if (eff_state == MESI_M) begin
               result     = SNOOP_HITM;
               msg        = MSG_EVICTLINE;
               wb         = 1'b1;
               next_state = MESI_I;
            end else if (eff_state == MESI_E || eff_state == MESI_S) begin
               result     = SNOOP_HIT;
               msg        = MSG_INVALIDATELINE;
               next_state = MESI_I;
            end
         end
         default: begin
         end
      endcase
      update = (next_state != eff_state);
   end

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder for the shared last-level cache. Accepts one snooped bus op at a time,
// looks up the line, reports NOHIT/HIT/HITM, then runs the L1 message, writeback and
// MESI state update the op requires.
// Optional build macro SNOOP_STATS_EN adds saturating hit_cnt / hitm_cnt outputs.
module snoop_responder
   import snoop_responder_pkg::*;
#(
   parameter int I_SIZE = DEF_I_SIZE,
   parameter int C_SIZE = DEF_C_SIZE,
   parameter int D_SIZE = DEF_D_SIZE,
   parameter int A_SIZE = DEF_A_SIZE
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef SNOOP_STATS_EN
   output logic [31:0]      hit_cnt,
   output logic [31:0]      hitm_cnt,
`endif
   snoop_responder_if.slave bus
);

   localparam int IDX_W  = idx_width(C_SIZE, D_SIZE, A_SIZE);
   localparam int TAG_W  = tag_width(I_SIZE, C_SIZE, D_SIZE, A_SIZE);
   localparam int WAY_W  = $clog2(A_SIZE);
   localparam int LINE_W = I_SIZE - D_SIZE;

   resp_state_t       state, state_next;
   bus_op_t           op_q;
   logic [LINE_W-1:0] line_q;
   logic              hit_q;
   logic [WAY_W-1:0]  way_q;
   mesi_t             mesi_q;

   snoop_result_t     dec_result;
   l2l1_msg_t         dec_msg;
   logic              dec_wb;
   mesi_t             dec_next;
   logic              dec_update;

   snoop_action_decode u_decode (
      .op         (op_q),
      .hit        (hit_q),
      .state      (mesi_q),
      .result     (dec_result),
      .msg        (dec_msg),
      .wb         (dec_wb),
      .next_state (dec_next),
      .update     (dec_update)
   );

   // State register plus the snoop and lookup captures that the later phases replay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op_q   <= OP_READ;
         line_q <= '0;
         hit_q  <= 1'b0;
         way_q  <= '0;
         mesi_q <= MESI_I;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && bus.snoop_valid) begin
            op_q   <= bus_op_t'(bus.snoop_op);
            line_q <= bus.snoop_addr[I_SIZE-1:D_SIZE];
         end
         if (state == ST_LOOKUP) begin
            hit_q  <= bus.lk_hit;
            way_q  <= bus.lk_way;
            mesi_q <= mesi_t'(bus.lk_state);
         end
      end
   end

   // Next-state and output decode; optional phases are skipped when the action table needs none.
   always_comb begin
      state_next       = state;
      bus.snoop_ready  = 1'b0;
      bus.lk_req       = 1'b0;
      bus.lk_index     = '0;
      bus.lk_tag       = '0;
      bus.result_valid = 1'b0;
      bus.snoop_result = SNOOP_NOHIT;
      bus.l1_valid     = 1'b0;
      bus.l1_msg       = MSG_NONE;
      bus.wb_valid     = 1'b0;
      bus.wb_addr      = '0;
      bus.st_we        = 1'b0;
      bus.st_index     = '0;
      bus.st_way       = '0;
      bus.st_state     = MESI_I;
      unique case (state)
         ST_IDLE: begin
            bus.snoop_ready = 1'b1;
            if (bus.snoop_valid) state_next = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            bus.lk_req   = 1'b1;
            bus.lk_index = line_q[IDX_W-1:0];
            bus.lk_tag   = line_q[LINE_W-1 -: TAG_W];
            state_next   = ST_RESULT;
         end
         ST_RESULT: begin
            bus.result_valid = 1'b1;
            bus.snoop_result = dec_result;
            if (dec_msg != MSG_NONE) state_next = ST_L1MSG;
            else if (dec_wb)         state_next = ST_WB;
            else if (dec_update)     state_next = ST_UPDATE;
            else                     state_next = ST_IDLE;
         end
         ST_L1MSG: begin
            bus.l1_valid = 1'b1;
            bus.l1_msg   = dec_msg;
            if (bus.l1_ack) begin
               if (dec_wb)          state_next = ST_WB;
               else if (dec_update) state_next = ST_UPDATE;
               else                 state_next = ST_IDLE;
            end
         end
         ST_WB: begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = {line_q, {D_SIZE{1'b0}}};
            if (bus.wb_ready) state_next = dec_update ? ST_UPDATE : ST_IDLE;
         end
         ST_UPDATE: begin
            bus.st_we    = 1'b1;
            bus.st_index = line_q[IDX_W-1:0];
            bus.st_way   = way_q;
            bus.st_state = dec_next;
            state_next   = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef SNOOP_STATS_EN
   // Saturating HIT / HITM counters, bumped once per snoop in the result cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         hitm_cnt <= '0;
      end else if (state == ST_RESULT) begin
         if (dec_result == SNOOP_HIT && hit_cnt != '1)   hit_cnt  <= hit_cnt + 32'd1;
         if (dec_result == SNOOP_HITM && hitm_cnt != '1) hitm_cnt <= hitm_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: a scoreboard of expected snoop outcomes is filled
// as snoops are driven and drained by a monitor as the responder reports results and actions.
module tb_snoop_responder;

   localparam int I_SIZE = 32;
   localparam int C_SIZE = 24;
   localparam int D_SIZE = 6;
   localparam int A_SIZE = 8;
   localparam int IDX_W  = C_SIZE - D_SIZE - $clog2(A_SIZE);
   localparam int TAG_W  = I_SIZE - IDX_W - D_SIZE;

   typedef struct packed {
      logic [1:0]       result;
      logic [1:0]       msg;
      logic             has_wb;
      logic [31:0]      wb_addr;
      logic             has_st;
      logic [IDX_W-1:0] st_index;
      logic [2:0]       st_way;
      logic [1:0]       st_state;
      int               done_lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic snoop_valid;
   logic [1:0] snoop_op;
   logic [31:0] snoop_addr;
   logic t_hit;
   logic [2:0] t_way;
   logic [1:0] t_state;
   logic [31:0] t_addr;
   logic l1_ack;
   logic wb_ready;
   int l1_delay, wb_delay, l1_cnt, wb_cnt;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int prev_accept = 0;
   int accept_cnt = 0;
   int l1_seen, wb_seen, st_seen;
   logic cur_active = 1'b0;
   exp_t cur;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   snoop_responder_if #(.I_SIZE(I_SIZE), .C_SIZE(C_SIZE), .D_SIZE(D_SIZE), .A_SIZE(A_SIZE)) bus ();

   assign bus.snoop_valid = snoop_valid;
   assign bus.snoop_op    = snoop_op;
   assign bus.snoop_addr  = snoop_addr;
   assign bus.lk_hit      = t_hit;
   assign bus.lk_way      = t_way;
   assign bus.lk_state    = t_state;
   assign bus.l1_ack      = l1_ack;
   assign bus.wb_ready    = wb_ready;

`ifdef SNOOP_STATS_EN
   logic [31:0] hit_cnt, hitm_cnt;
`endif

   snoop_responder #(.I_SIZE(I_SIZE), .C_SIZE(C_SIZE), .D_SIZE(D_SIZE), .A_SIZE(A_SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef SNOOP_STATS_EN
      .hit_cnt  (hit_cnt),
      .hitm_cnt (hitm_cnt),
`endif
      .bus   (bus)
   );

   // Count one comparison and report it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Reference behaviour of one snoop, written straight from the MESI action table.
   function automatic exp_t model(input logic [1:0] op, input logic hit, input logic [1:0] st,
                                  input logic [31:0] addr, input logic [2:0] way);
      exp_t e;
      logic [1:0] eff;
      logic [1:0] nxt;
      eff = hit ? st : 2'd0;
      nxt = eff;
      e = '0;
      case (op)
         2'd0: if (eff == 2'd3) begin e.result = 2'd2; e.msg = 2'd1; e.has_wb = 1'b1; nxt = 2'd1; end
               else if (eff != 2'd0) begin e.result = 2'd1; nxt = 2'd1; end
         2'd2: if (eff == 2'd1) begin e.result = 2'd1; e.msg = 2'd2; nxt = 2'd0; end
         2'd3: if (eff == 2'd3) begin e.result = 2'd2; e.msg = 2'd3; e.has_wb = 1'b1; nxt = 2'd0; end
               else if (eff != 2'd0) begin e.result = 2'd1; e.msg = 2'd2; nxt = 2'd0; end
         default: ;
      endcase
      e.wb_addr  = {addr[31:6], 6'd0};
      e.has_st   = (nxt != eff);
      e.st_index = addr[D_SIZE +: IDX_W];
      e.st_way   = way;
      e.st_state = nxt;
      if (e.msg == 2'd0 && !e.has_wb) e.done_lat = e.has_st ? 4 : 3;
      else                            e.done_lat = -1;
      return e;
   endfunction

   // L1 side: acknowledge a pending message after l1_delay cycles.
   always @(negedge clk) begin
      if (bus.l1_valid) begin
         l1_ack = (l1_cnt >= l1_delay);
         l1_cnt++;
      end else begin
         l1_ack = 1'b0;
         l1_cnt = 0;
      end
   end

   // Writeback side: accept a pending writeback after wb_delay cycles.
   always @(negedge clk) begin
      if (bus.wb_valid) begin
         wb_ready = (wb_cnt >= wb_delay);
         wb_cnt++;
      end else begin
         wb_ready = 1'b0;
         wb_cnt = 0;
      end
   end

   // Monitor: sample just after the falling edge and drain the scoreboard.
   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
         cur_active = 1'b0;
      end else begin
         if (cur_active && bus.snoop_ready) begin
            checkOutput("l1_count", 64'(l1_seen), 64'(cur.msg != 2'd0));
            checkOutput("wb_count", 64'(wb_seen), 64'(cur.has_wb));
            checkOutput("st_count", 64'(st_seen), 64'(cur.has_st));
            if (cur.done_lat >= 0)
               checkOutput("ready_return", 64'(cyc - accept_cyc), 64'(cur.done_lat));
            cur_active = 1'b0;
         end
         if (bus.snoop_valid && bus.snoop_ready) begin
            prev_accept = accept_cyc;
            accept_cyc  = cyc;
            accept_cnt++;
         end
         if (bus.lk_req) begin
            checkOutput("lk_index", 64'(bus.lk_index), 64'(t_addr[D_SIZE +: IDX_W]));
            checkOutput("lk_tag", 64'(bus.lk_tag), 64'(t_addr[31 -: TAG_W]));
         end
         if (bus.result_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_result", 64'(bus.result_valid), 64'(0));
            end else begin
               cur = exp_q.pop_front();
               cur_active = 1'b1;
               l1_seen = 0;
               wb_seen = 0;
               st_seen = 0;
               checkOutput("result_latency", 64'(cyc - accept_cyc), 64'(2));
               checkOutput("snoop_result", 64'(bus.snoop_result), 64'(cur.result));
            end
         end
         if (!cur_active) begin
            if (bus.l1_valid || bus.wb_valid || bus.st_we)
               checkOutput("spurious_action", 64'({bus.l1_valid, bus.wb_valid, bus.st_we}), 64'(0));
         end else begin
            if (bus.l1_valid) begin
               checkOutput("l1_msg", 64'(bus.l1_msg), 64'(cur.msg));
               if (l1_ack) l1_seen++;
            end
            if (bus.wb_valid) begin
               checkOutput("wb_after_l1", 64'(l1_seen), 64'(1));
               checkOutput("wb_addr", 64'(bus.wb_addr), 64'(cur.wb_addr));
               if (wb_ready) wb_seen++;
            end
            if (bus.st_we) begin
               checkOutput("st_index", 64'(bus.st_index), 64'(cur.st_index));
               checkOutput("st_way", 64'(bus.st_way), 64'(cur.st_way));
               checkOutput("st_state", 64'(bus.st_state), 64'(cur.st_state));
               st_seen++;
            end
         end
      end
   end

   // Drive one snoop, record its expected outcome and hold snoop_valid until it is taken.
   task automatic sendSnoop(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                            input logic [2:0] way, input logic [1:0] st, input int l1d, input int wbd);
      int start;
      int n;
      @(negedge clk);
      t_addr = addr; t_hit = hit; t_way = way; t_state = st;
      l1_delay = l1d; wb_delay = wbd;
      exp_q.push_back(model(op, hit, st, addr, way));
      snoop_op = op; snoop_addr = addr; snoop_valid = 1'b1;
      start = accept_cnt;
      n = 0;
      #3;
      while (accept_cnt == start && n < 200) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (accept_cnt == start) checkOutput("accept_timeout", 64'(accept_cnt - start), 64'(1));
      @(negedge clk);
      snoop_valid = 1'b0;
   endtask

   // Wait, within a cycle budget, until every expected snoop has been fully retired.
   task automatic waitIdle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || cur_active) && n < 500) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (exp_q.size() != 0 || cur_active)
         checkOutput("done_timeout", 64'(exp_q.size() + int'(cur_active)), 64'(0));
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                                input logic [2:0] way, input logic [1:0] st, input int l1d, input int wbd);
      sendSnoop(op, addr, hit, way, st, l1d, wbd);
      waitIdle();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int start;
      rst_n = 1'b0;
      snoop_valid = 1'b0; snoop_op = 2'd0; snoop_addr = '0;
      t_hit = 1'b0; t_way = '0; t_state = '0; t_addr = '0;
      l1_delay = 0; wb_delay = 0; l1_cnt = 0; wb_cnt = 0;
      l1_ack = 1'b0; wb_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #3;
      checkOutput("reset_ready", 64'(bus.snoop_ready), 64'(1));
      checkOutput("reset_result_valid", 64'(bus.result_valid), 64'(0));
      checkOutput("reset_lk_req", 64'(bus.lk_req), 64'(0));
      checkOutput("reset_l1_valid", 64'(bus.l1_valid), 64'(0));
      checkOutput("reset_wb_valid", 64'(bus.wb_valid), 64'(0));
      checkOutput("reset_st_we", 64'(bus.st_we), 64'(0));

      // Directed cases from the action table, including late handshakes and a miss on an M state.
      applyStimulus(2'd0, 32'h0ABC_DEF5, 1'b1, 3'd5, 2'd3, 2, 3);
      applyStimulus(2'd3, 32'h1234_5678, 1'b1, 3'd3, 2'd2, 0, 0);
      applyStimulus(2'd1, 32'h0000_4040, 1'b1, 3'd1, 2'd3, 0, 0);
      applyStimulus(2'd0, 32'hFFFF_FFFF, 1'b0, 3'd7, 2'd3, 0, 0);
      applyStimulus(2'd0, 32'h8000_0000, 1'b1, 3'd2, 2'd1, 0, 0);
      applyStimulus(2'd0, 32'h0101_0101, 1'b1, 3'd6, 2'd2, 0, 0);
      applyStimulus(2'd2, 32'h2222_2200, 1'b1, 3'd4, 2'd1, 1, 0);
      applyStimulus(2'd2, 32'h3333_3300, 1'b1, 3'd4, 2'd3, 0, 0);
      applyStimulus(2'd3, 32'h4444_44C3, 1'b1, 3'd0, 2'd3, 0, 0);
      applyStimulus(2'd3, 32'h5555_5555, 1'b1, 3'd1, 2'd1, 3, 0);
      applyStimulus(2'd3, 32'h6666_6666, 1'b1, 3'd1, 2'd0, 0, 0);

      // Asynchronous reset while the writeback is still waiting for wb_ready.
      sendSnoop(2'd0, 32'h0000_1FC0, 1'b1, 3'd2, 2'd3, 0, 1000);
      n = 0;
      while (!bus.wb_valid && n < 100) begin
         @(negedge clk);
         #3;
         n++;
      end
      checkOutput("wb_wait_reached", 64'(bus.wb_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("abort_wb_valid", 64'(bus.wb_valid), 64'(0));
      checkOutput("abort_l1_valid", 64'(bus.l1_valid), 64'(0));
      checkOutput("abort_st_we", 64'(bus.st_we), 64'(0));
      checkOutput("abort_result_valid", 64'(bus.result_valid), 64'(0));
      checkOutput("abort_lk_req", 64'(bus.lk_req), 64'(0));
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wb_delay = 0;
      repeat (10) @(negedge clk);
      applyStimulus(2'd0, 32'h0000_1FC0, 1'b1, 3'd2, 2'd2, 0, 0);

      // Back-to-back: snoop_valid held high across two snoops.
      @(negedge clk);
      t_addr = 32'h7777_7700; t_hit = 1'b1; t_way = 3'd3; t_state = 2'd1;
      exp_q.push_back(model(2'd0, 1'b1, 2'd1, 32'h7777_7700, 3'd3));
      exp_q.push_back(model(2'd0, 1'b1, 2'd1, 32'h7777_7700, 3'd3));
      snoop_op = 2'd0; snoop_addr = 32'h7777_7700; snoop_valid = 1'b1;
      start = accept_cnt;
      n = 0;
      #3;
      while (accept_cnt - start < 2 && n < 200) begin
         @(negedge clk);
         #3;
         n++;
      end
      @(negedge clk);
      snoop_valid = 1'b0;
      checkOutput("b2b_accepts", 64'(accept_cnt - start), 64'(2));
      checkOutput("b2b_gap", 64'(accept_cyc - prev_accept), 64'(3));
      waitIdle();

      // Random mix of ops, states, hits and handshake delays.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       $urandom_range(0, 3), $urandom_range(0, 3));
      end

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
